// File: rtl/btb_predictor_if.sv
// Fetch/EX-side signal bundle for the branch target buffer: lookup, resolution
// update, control and statistics readout.
interface btb_predictor_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [31:0]      pred_target;

  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_pred_taken;
  logic [31:0]      upd_pred_target;
  logic             mispredict;
  logic [31:0]      redirect_pc;

  logic             flush_all;
  logic             stat_clr;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispred_count;

  // Pipeline side
  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, flush_all, stat_clr,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispred_count
  );

  // Predictor side
  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, flush_all, stat_clr,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispred_count
  );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters, zero-latency
// lookup, EX-stage misprediction detection and saturating branch statistics.
module btb_predictor #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 10,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            reset,
  btb_predictor_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic             kbit_q   [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [CNT_W-1:0] stat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             mispredict;

  // Fetch-side lookup: purely combinational from the registered table
  assign lk_idx   = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag   = bus.lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) &&
                    (kbit_q[lk_idx] == bus.lookup_pc[31]);
  assign lk_taken = lk_hit && cnt_q[lk_idx][1];

  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_taken;
  assign bus.pred_target = lk_taken ? target_q[lk_idx] : bus.lookup_pc + 32'd4;

  // EX-side resolution: compare actual outcome against the carried prediction
  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag) &&
                  (kbit_q[up_idx] == bus.upd_pc[31]);

  assign mispredict = bus.upd_valid &&
                      ((bus.upd_taken != bus.upd_pred_taken) ||
                       (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));

  assign bus.mispredict  = mispredict;
  assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;

  // Table write: flush wins over a same-edge update, which is then dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        kbit_q[i]   <= 1'b0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b00;
      end
    end else if (bus.flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (bus.upd_valid) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          cnt_q[up_idx]    <= sat_inc(cnt_q[up_idx]);
          target_q[up_idx] <= bus.upd_target;
        end else begin
          cnt_q[up_idx]    <= sat_dec(cnt_q[up_idx]);
        end
      end else if (bus.upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        kbit_q[up_idx]   <= bus.upd_pc[31];
        target_q[up_idx] <= bus.upd_target;
        cnt_q[up_idx]    <= 2'b10;
      end
    end
  end

  // Statistics: clear beats increment; both counters stick at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (bus.stat_clr) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (bus.upd_valid) branch_cnt_q  <= stat_inc(branch_cnt_q);
      if (mispredict)    mispred_cnt_q <= stat_inc(mispred_cnt_q);
    end
  end

  assign bus.branch_count  = branch_cnt_q;
  assign bus.mispred_count = mispred_cnt_q;
endmodule

// File: tb/tb_btb_predictor.sv
// Randomized and directed bench for btb_predictor against an array-based
// reference of the predictor's table and statistics.
module tb_btb_predictor;
  localparam int IDX_W   = 4;
  localparam int TAG_W   = 10;
  localparam int CNT_W   = 4;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  btb_predictor_if #(.CNT_W(CNT_W)) bus ();

  btb_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: one slot per index, key = supervisor bit and tag field
  bit          m_valid [ENTRIES];
  longint      m_key   [ENTRIES];
  bit [31:0]   m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  int          m_br;
  int          m_mp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int m_idx(input bit [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic longint m_keyof(input bit [31:0] pc);
    longint hi;
    hi = longint'(pc >> (IDX_W + 2)) % (longint'(1) << TAG_W);
    return (pc[31] ? (longint'(1) << TAG_W) : 0) + hi;
  endfunction

  function automatic bit m_hit(input bit [31:0] pc);
    return m_valid[m_idx(pc)] && (m_key[m_idx(pc)] == m_keyof(pc));
  endfunction

  function automatic bit m_ptaken(input bit [31:0] pc);
    return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
  endfunction

  function automatic bit [31:0] m_ptarget(input bit [31:0] pc);
    return m_ptaken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_misp();
    return bus.upd_valid && ((bus.upd_taken != bus.upd_pred_taken) ||
           (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
  endfunction

  function automatic bit [31:0] rand_pc();
    return (32'($urandom_range(0, 1)) << 31) | 32'h0040_0000 |
           (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_key[i] = 0; m_tgt[i] = '0; m_cnt[i] = 0;
    end
    m_br = 0; m_mp = 0;
  endtask

  task automatic m_step();
    bit mp;
    int i;
    mp = m_misp();
    i  = m_idx(bus.upd_pc);
    if (bus.flush_all) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    end else if (bus.upd_valid) begin
      if (m_hit(bus.upd_pc)) begin
        if (bus.upd_taken) begin
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_tgt[i] = bus.upd_target;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (bus.upd_taken) begin
        m_valid[i] = 1'b1;
        m_key[i]   = m_keyof(bus.upd_pc);
        m_tgt[i]   = bus.upd_target;
        m_cnt[i]   = 2;
      end
    end
    if (bus.stat_clr) begin
      m_br = 0; m_mp = 0;
    end else begin
      if (bus.upd_valid) m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
      if (mp)            m_mp = (m_mp < CMAX) ? m_mp + 1 : CMAX;
    end
  endtask

  task automatic check_all();
    chk("hit",    32'(bus.pred_hit),      32'(m_hit(bus.lookup_pc)));
    chk("taken",  32'(bus.pred_taken),    32'(m_ptaken(bus.lookup_pc)));
    chk("target", bus.pred_target,        m_ptarget(bus.lookup_pc));
    chk("misp",   32'(bus.mispredict),    32'(m_misp()));
    if (m_misp())
      chk("redirect", bus.redirect_pc, bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4);
    chk("br_cnt", 32'(bus.branch_count),  32'(m_br));
    chk("mp_cnt", 32'(bus.mispred_count), 32'(m_mp));
  endtask

  // Called at posedge+1; checks combinational outputs, then advances one edge
  task automatic cycle();
    #2;
    check_all();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic drive(input bit v, input bit [31:0] pc, input bit t, input bit [31:0] tg,
                       input bit pt, input bit [31:0] ptg);
    bus.upd_valid = v; bus.upd_pc = pc; bus.upd_taken = t; bus.upd_target = tg;
    bus.upd_pred_taken = pt; bus.upd_pred_target = ptg;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.flush_all = 1'b0;
    bus.stat_clr  = 1'b0;
  endtask

  localparam bit [31:0] PC_A = 32'h0040_0010;
  localparam bit [31:0] PC_B = 32'h0040_0050;
  localparam bit [31:0] PC_C = 32'h0040_0090;
  localparam bit [31:0] T_A  = 32'h0040_0100;
  localparam bit [31:0] T_B  = 32'h0040_0200;

  initial begin
    bus.lookup_pc = PC_A;
    idle();
    m_reset();
    #1 reset = 1'b1;
    #10 reset = 1'b0;

    // Reset state
    #2;
    chk("rst_hit",    32'(bus.pred_hit),      32'd0);
    chk("rst_taken",  32'(bus.pred_taken),    32'd0);
    chk("rst_target", bus.pred_target,        32'h0040_0014);
    chk("rst_br",     32'(bus.branch_count),  32'd0);
    chk("rst_mp",     32'(bus.mispred_count), 32'd0);
    cycle();

    // First taken branch allocates and mispredicts
    drive(1'b1, PC_A, 1'b1, T_A, 1'b0, 32'h0);
    #2;
    chk("alloc_misp",     32'(bus.mispredict), 32'd1);
    chk("alloc_redirect", bus.redirect_pc,     T_A);
    cycle();
    idle();
    #2;
    chk("alloc_hit",    32'(bus.pred_hit),      32'd1);
    chk("alloc_taken",  32'(bus.pred_taken),    32'd1);
    chk("alloc_target", bus.pred_target,        T_A);
    chk("alloc_mp",     32'(bus.mispred_count), 32'd1);
    chk("alloc_br",     32'(bus.branch_count),  32'd1);
    cycle();

    // Counter saturation and hysteresis
    repeat (2) begin drive(1'b1, PC_A, 1'b1, T_A, 1'b1, T_A); cycle(); end
    drive(1'b1, PC_A, 1'b0, 32'h0, 1'b1, T_A); cycle();
    idle(); #2; chk("hyst_taken", 32'(bus.pred_taken), 32'd1); cycle();
    drive(1'b1, PC_A, 1'b0, 32'h0, 1'b1, T_A); cycle();
    idle(); #2;
    chk("weak_taken",  32'(bus.pred_taken), 32'd0);
    chk("weak_hit",    32'(bus.pred_hit),   32'd1);
    chk("weak_target", bus.pred_target,     32'h0040_0014);
    cycle();
    repeat (3) begin drive(1'b1, PC_A, 1'b0, 32'h0, 1'b0, 32'h0); cycle(); end
    drive(1'b1, PC_A, 1'b1, T_A, 1'b0, 32'h0); cycle();
    idle(); #2; chk("floor_taken", 32'(bus.pred_taken), 32'd0); cycle();

    // Supervisor bit and index aliasing
    bus.lookup_pc = 32'h8040_0010;
    #2; chk("kbit_hit", 32'(bus.pred_hit), 32'd0);
    cycle();
    drive(1'b1, PC_B, 1'b1, T_B, 1'b0, 32'h0); cycle();
    idle(); bus.lookup_pc = PC_A;
    #2; chk("evict_hit", 32'(bus.pred_hit), 32'd0);
    cycle();
    bus.lookup_pc = PC_B;
    #2;
    chk("newent_taken",  32'(bus.pred_taken), 32'd1);
    chk("newent_target", bus.pred_target,     T_B);
    cycle();

    // Same-edge lookup and update: old state now, new state next cycle
    drive(1'b1, PC_B, 1'b0, 32'h0, 1'b1, T_B);
    #2; chk("sim_old", 32'(bus.pred_taken), 32'd1);
    cycle();
    idle();
    #2;
    chk("sim_new_taken", 32'(bus.pred_taken), 32'd0);
    chk("sim_new_hit",   32'(bus.pred_hit),   32'd1);
    cycle();

    // Flush beats a simultaneous allocation but the branch is still counted
    bus.flush_all = 1'b1;
    drive(1'b1, PC_C, 1'b1, T_A, 1'b0, 32'h0);
    cycle();
    idle(); bus.lookup_pc = PC_B;
    #2; chk("flush_hit_b", 32'(bus.pred_hit), 32'd0);
    cycle();
    bus.lookup_pc = PC_C;
    #2;
    chk("flush_hit_c", 32'(bus.pred_hit),     32'd0);
    chk("flush_br",    32'(bus.branch_count), 32'd12);
    cycle();

    // Statistics saturation and clear priority
    repeat (20) begin drive(1'b1, rand_pc(), 1'b0, 32'h0, 1'b1, T_A); cycle(); end
    idle(); #2;
    chk("sat_br", 32'(bus.branch_count),  32'(CMAX));
    chk("sat_mp", 32'(bus.mispred_count), 32'(CMAX));
    cycle();
    bus.stat_clr = 1'b1;
    drive(1'b1, PC_A, 1'b0, 32'h0, 1'b1, T_A);
    cycle();
    idle(); #2;
    chk("clr_br", 32'(bus.branch_count),  32'd0);
    chk("clr_mp", 32'(bus.mispred_count), 32'd0);
    cycle();

    // Randomized traffic against the reference
    for (int k = 0; k < 600; k++) begin
      bit [31:0] pc;
      pc = rand_pc();
      bus.upd_valid  = ($urandom_range(0, 3) != 0);
      bus.upd_pc     = pc;
      bus.upd_taken  = 1'($urandom_range(0, 1));
      bus.upd_target = 32'h0040_1000 + (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 1) == 1) begin
        bus.upd_pred_taken  = m_ptaken(pc);
        bus.upd_pred_target = m_ptarget(pc);
      end else begin
        bus.upd_pred_taken  = 1'($urandom_range(0, 1));
        bus.upd_pred_target = 32'h0040_1000 + (32'($urandom_range(0, 3)) << 2);
      end
      bus.lookup_pc = ($urandom_range(0, 2) == 0) ? pc : rand_pc();
      bus.flush_all = ($urandom_range(0, 39) == 0);
      bus.stat_clr  = ($urandom_range(0, 15) == 0);
      cycle();
    end

    // Asynchronous reset in the middle of an update
    idle();
    drive(1'b1, PC_A, 1'b1, T_A, 1'b0, 32'h0); cycle();
    bus.lookup_pc = PC_A;
    drive(1'b1, PC_B, 1'b1, T_B, 1'b0, 32'h0);
    #3 reset = 1'b1;
    m_reset();
    #1;
    chk("arst_hit",      32'(bus.pred_hit),      32'd0);
    chk("arst_taken",    32'(bus.pred_taken),    32'd0);
    chk("arst_target",   bus.pred_target,        32'h0040_0014);
    chk("arst_br",       32'(bus.branch_count),  32'd0);
    chk("arst_mp",       32'(bus.mispred_count), 32'd0);
    chk("arst_misp",     32'(bus.mispredict),    32'd1);
    chk("arst_redirect", bus.redirect_pc,        T_B);
    #1 reset = 1'b0;
    cycle();
    idle();
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters for the next-generation pipelined CPU.
- Gives the fetch stage a same-cycle taken/target prediction for the current PC.
- Accepts branch resolution from EX, updates its tables, and flags mispredictions so the pipeline can redirect.
- Replaces the fixed "predict not-taken, flush on taken branch" behaviour of the current pipeline; also keeps saturating branch/mispredict statistics.

Parameters:
IDX_W, 4, index bits; table holds 2^IDX_W entries, indexed by pc[IDX_W+1:2]
TAG_W, 10, tag bits taken from pc[IDX_W+TAG_W+1:IDX_W+2]; requires IDX_W+TAG_W <= 29
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
lookup_pc  in  32  fetch-stage PC
pred_hit  out  1  valid entry with matching tag for lookup_pc
pred_taken  out  1  predicted taken (pred_hit && counter[1])
pred_target  out  32  stored target if pred_taken, else lookup_pc+4
upd_valid  in  1  one resolved branch this cycle
upd_pc  in  32  PC of resolved branch
upd_taken  in  1  actual direction
upd_target  in  32  actual taken target
upd_pred_taken  in  1  prediction carried down the pipe with this branch
upd_pred_target  in  32  predicted target carried down the pipe
mispredict  out  1  resolution disagrees with carried prediction
redirect_pc  out  32  correct next PC: upd_target if upd_taken, else upd_pc+4
flush_all  in  1  invalidate every entry (exception/interrupt entry, ROM reload)
stat_clr  in  1  synchronous clear of statistics
branch_count  out  CNT_W  resolved branches, saturating
mispred_count  out  CNT_W  mispredictions, saturating

Behaviour:
- Entry fields: valid, tag, kbit (pc[31], supervisor bit), target[31:0], cnt[1:0].
- Tag match requires valid && tag == pc[IDX_W+TAG_W+1:IDX_W+2] && kbit == pc[31]. User-mode and supervisor-mode PCs never alias.
- Lookup is combinational from registered table state; zero latency.
- No write bypass: an update landing on the same edge is not visible to a same-cycle lookup; it is visible from the next cycle.
- mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)). Combinational; 0 when upd_valid=0.
- redirect_pc is combinational, +4 with 32-bit wrap; it is meaningful only when mispredict=1.
- Update on rising edge when upd_valid=1 and flush_all=0:
  - Hit, taken: cnt = sat_inc(cnt), target = upd_target.
  - Hit, not taken: cnt = sat_dec(cnt), target unchanged, entry stays valid.
  - Miss, taken: allocate/overwrite the indexed entry (direct-mapped): valid=1, tag, kbit, target, cnt=2'b10.
  - Miss, not taken: no table change.
- Counter saturation: 3 stays 3 on taken; 0 stays 0 on not-taken.
- flush_all: all valid bits cleared on the next edge. It takes priority over a simultaneous update, which is dropped from the table. Statistics still count that update.
- Statistics:
  - branch_count increments on upd_valid; mispred_count increments on mispredict.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - stat_clr sets both to 0 and has priority over a same-cycle increment.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits 0, cnt 0, targets 0; counters 0.
  - Outputs then read pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
  - mispredict and redirect_pc follow the upd_* inputs combinationally.
- Tables need no reset beyond the valid bits, but targets and cnt are reset as well so simulation is X-free.

Test Plan:
- After reset, lookup_pc=0x00400010 -> pred_hit=0, pred_taken=0, pred_target=0x00400014; branch_count=0, mispred_count=0.
- Update pc=0x00400010, taken, target=0x00400100, pred_taken=0 -> same cycle mispredict=1, redirect_pc=0x00400100. Next cycle: lookup of 0x00400010 gives hit, taken, target 0x00400100; mispred_count=1, branch_count=1.
- Counter saturation and hysteresis on that entry:
  - Two taken updates -> cnt=3.
  - Then one not-taken -> still predicts taken (cnt=2).
  - A second not-taken -> pred_taken=0, pred_hit=1, pred_target=pc+4.
  - Three more not-taken -> cnt stays 0.
- Aliasing: allocate 0x00400010, then lookup 0x80400010 (kbit differs) -> pred_hit=0. A taken update at 0x00400050 (same index for IDX_W=4) replaces the entry -> 0x00400010 misses.
- Simultaneous events:
  - Lookup and update to the same PC on one edge -> lookup shows the old state that cycle and the new state the next cycle.
  - flush_all together with a taken update -> table empty afterwards, branch_count still increments.
- Statistics: with CNT_W=4, 20 mispredicting updates -> both counters read 15. stat_clr asserted with upd_valid -> both read 0 next cycle. Reset asserted mid-stream -> all outputs return to reset values without a clock edge.
